pipe_icache: RTL and testbench
==============================

// Module: pipe_icache
// PURPOSE
//   Direct-mapped instruction cache between the IF stage and the 256-bit block instruction memory.
//   Hits return a 32-bit instruction in the same cycle; misses stall IF and refill a whole 32B line.
//   The memory side drives a block-read request (mem_en, mem_addr) and consumes mem_data/mem_ready.
// PARAMETERS
//   LINES      16  number of cache lines, power of 2, >=2; IDX_W = log2(LINES)
//   ADDR_W     32  byte address width
//   LINE_BITS  256 line width; fixed at 8 x 32-bit words, word select = addr[4:2]
// PORTS
//   clock      in   1    rising-edge clock
//   resetn     in   1    asynchronous active-low reset
//   cpu_req    in   1    IF fetch request valid
//   cpu_addr   in   32   fetch byte address; addr[1:0] ignored
//   cpu_inst   out  32   instruction, valid when cpu_req & ~cpu_stall
//   cpu_stall  out  1    freeze PC/IF; high from miss detection until response
//   mem_en     out  1    block read enable to instruction memory
//   mem_addr   out  32   line-aligned refill address {miss_tag, miss_idx, 5'b0}
//   mem_ready  in   1    memory data valid (sampled only in FILL_WAIT)
//   mem_data   in   256  refill line; word k at bits [32k+31:32k]
// BEHAVIOUR
//   - Address split: tag = addr[31:5+IDX_W], idx = addr[5+IDX_W-1:5], word = addr[4:2].
//   - Storage: valid[LINES], tag[LINES], data[LINES] x 256; valid cleared by reset only.
//   - Reset (async): state=IDLE, all valid=0, mem_en=0, mem_addr=0, cpu_stall=0, cpu_inst=0.
//   - FSM states: IDLE, FILL_REQ, FILL_WAIT, RESP.
//   - IDLE: hit = cpu_req & valid[idx] & tag match -> cpu_inst = data[idx][word] combinationally,
//     cpu_stall=0. Miss -> cpu_stall=1 same cycle, latch miss_addr, next state FILL_REQ.
//     cpu_req=0 -> cpu_stall=0, cpu_inst=0.
//   - FILL_REQ (1 cycle): mem_en=1, mem_addr=line address; mem_ready ignored; -> FILL_WAIT.
//   - FILL_WAIT: mem_en=1 held; on mem_ready=1 write data/tag, set valid, latch line into
//     fill buffer, -> RESP. Wait unbounded otherwise; no timeout.
//   - RESP (1 cycle): mem_en=0, cpu_stall=0, cpu_inst = fill_buf[miss_word]; -> IDLE.
//   - Minimum miss penalty: 3 stall cycles (detect, FILL_REQ, FILL_WAIT with ready), response 4th.
//   - cpu_stall=1 in every cycle of FILL_REQ and FILL_WAIT; mem_en=0 in IDLE and RESP.
//   - IF holds cpu_addr stable while stalled; cache uses latched miss_addr regardless.
//   - cpu_req dropping mid-refill: refill still completes and line installed; RESP
//     drives cpu_inst but IF discards it.
//   - Line replacement: refill overwrites idx unconditionally (no write-back, read-only cache).
//   - resetn low mid-refill: abort immediately, mem_en=0, line not installed, all lines invalid.
//   - Back-to-back misses: IDLE after RESP re-evaluates the new address; no lost request.
// CONFIGURATION
//   ICACHE_STATS_EN defined: add outputs hit_cnt[31:0], miss_cnt[31:0]; hit_cnt +1 per
//     IDLE-cycle hit, miss_cnt +1 per miss detection; both saturate at 32'hFFFF_FFFF,
//     reset to 0 asynchronously.
//   ICACHE_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//   1. Reset, fetch 0x0000_0000 -> stall 3 cycles, mem_addr=0x0, then cpu_inst = word 0 of block 0.
//   2. After 1, fetch 0x04..0x1C consecutively -> 7 hits, cpu_stall=0 every cycle, no mem_en.
//   3. Fetch 0x0000_0200 (same idx 0 for LINES=16, new tag) -> miss, refill, then 0x0 misses again.
//   4. Hold mem_ready=0 for 10 cycles in FILL_WAIT -> mem_en and cpu_stall stay 1 throughout.
//   5. Pull resetn low in FILL_WAIT -> mem_en=0 at once; refetch same address misses again.
//   6. ICACHE_STATS_EN: run 1 and 2 -> miss_cnt=1, hit_cnt=7.

Source files
------------

// File: rtl/pipe_icache.sv
// Direct-mapped, read-only instruction cache between IF and a 256-bit block memory.
// Hits answer in the same cycle; a miss stalls IF and refills one 32-byte line.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module pipe_icache #(
    parameter int unsigned LINES  = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [31:0]       cpu_inst,
    output logic              cpu_stall,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
`ifdef ICACHE_STATS_EN
    input  logic [255:0]      mem_data,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`else
    input  logic [255:0]      mem_data
`endif
);

    localparam int unsigned LINE_BITS = 256;
    localparam int unsigned IDX_W     = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int unsigned TAG_W     = ADDR_W - 5 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]     valid_q;
    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [LINE_BITS-1:0] data_mem [LINES];

    logic [ADDR_W-1:2]    miss_addr_q;
    logic [LINE_BITS-1:0] fill_buf_q;

    logic [TAG_W-1:0]     req_tag;
    logic [IDX_W-1:0]     req_idx;
    logic [2:0]           req_word;
    logic [TAG_W-1:0]     miss_tag;
    logic [IDX_W-1:0]     miss_idx;
    logic [2:0]           miss_word;
    logic [LINE_BITS-1:0] hit_line;
    logic [31:0]          hit_word;
    logic [31:0]          fill_word;
    logic                 hit_c;
    logic                 miss_det;
    logic                 fill_we;
    logic                 unused_addr_lsb;

    // Address field split for the incoming fetch and the latched miss
    assign req_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
    assign req_idx   = cpu_addr[5 +: IDX_W];
    assign req_word  = cpu_addr[4:2];
    assign miss_tag  = miss_addr_q[ADDR_W-1 -: TAG_W];
    assign miss_idx  = miss_addr_q[5 +: IDX_W];
    assign miss_word = miss_addr_q[4:2];
    assign unused_addr_lsb = ^cpu_addr[1:0];

    // Lookup: tag compare and word select from the indexed line
    assign hit_line  = data_mem[req_idx];
    assign hit_word  = hit_line[{req_word, 5'b0} +: 32];
    assign fill_word = fill_buf_q[{miss_word, 5'b0} +: 32];
    assign hit_c     = cpu_req & valid_q[req_idx] & (tag_mem[req_idx] == req_tag);

    // Refill address is always the line-aligned latched miss address
    assign mem_addr = {miss_addr_q[ADDR_W-1:5], 5'b0};

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        cpu_stall = 1'b0;
        cpu_inst  = 32'h0;
        mem_en    = 1'b0;
        miss_det  = 1'b0;
        fill_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    if (hit_c) begin
                        cpu_inst = hit_word;
                    end else begin
                        cpu_stall = 1'b1;
                        miss_det  = 1'b1;
                        state_d   = S_FILL_REQ;
                    end
                end
            end
            S_FILL_REQ: begin
                cpu_stall = 1'b1;
                mem_en    = 1'b1;
                state_d   = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                cpu_stall = 1'b1;
                mem_en    = 1'b1;
                if (mem_ready) begin
                    fill_we = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cpu_inst = fill_word;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Valid bits: cleared only by reset, set when a refill lands
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
        end else if (fill_we) begin
            valid_q[miss_idx] <= 1'b1;
        end
    end

    // Miss address and fill buffer capture
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            miss_addr_q <= '0;
            fill_buf_q  <= '0;
        end else begin
            if (miss_det) begin
                miss_addr_q <= cpu_addr[ADDR_W-1:2];
            end
            if (fill_we) begin
                fill_buf_q <= mem_data;
            end
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set
    always_ff @(posedge clock) begin
        if (fill_we) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= mem_data;
        end
    end

`ifdef ICACHE_STATS_EN
    logic hit_evt;
    assign hit_evt = (state_q == S_IDLE) & hit_c;

    // Saturating hit/miss counters
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hit_cnt  <= 32'h0;
            miss_cnt <= 32'h0;
        end else begin
            if (hit_evt && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss_det && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_icache.sv
// Directed bench for pipe_icache: miss/refill timing, hits, conflict eviction,
// memory back-pressure, reset during refill, and optional statistics counters.
module tb_pipe_icache;

    logic         clock;
    logic         resetn;
    logic         cpu_req;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_inst;
    logic         cpu_stall;
    logic         mem_en;
    logic [31:0]  mem_addr;
    logic         mem_ready;
    logic [255:0] mem_data;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipe_icache dut (
        .clock     (clock),
        .resetn    (resetn),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_inst  (cpu_inst),
        .cpu_stall (cpu_stall),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
`ifdef ICACHE_STATS_EN
        .mem_data  (mem_data),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`else
        .mem_data  (mem_data)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory image: the word at byte address a holds a ^ 32'hDEAD_0000
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            mem_data[32*k +: 32] = (mem_addr | 32'(k << 2)) ^ 32'hDEAD_0000;
        end
    end

    function automatic logic [31:0] exp_inst(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full miss sequence with 'hold' extra FILL_WAIT cycles before mem_ready
    task automatic miss_seq(input logic [31:0] addr, input int hold);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        #1;
        chk("detect_stall", 32'(cpu_stall), 32'd1);
        chk("detect_mem_en", 32'(mem_en), 32'd0);
        tick();
        #1;
        chk("req_stall", 32'(cpu_stall), 32'd1);
        chk("req_mem_en", 32'(mem_en), 32'd1);
        chk("req_mem_addr", mem_addr, {addr[31:5], 5'b0});
        tick();
        for (int i = 0; i < hold; i++) begin
            #1;
            chk("wait_stall", 32'(cpu_stall), 32'd1);
            chk("wait_mem_en", 32'(mem_en), 32'd1);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("ready_stall", 32'(cpu_stall), 32'd1);
        chk("ready_mem_en", 32'(mem_en), 32'd1);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("resp_stall", 32'(cpu_stall), 32'd0);
        chk("resp_mem_en", 32'(mem_en), 32'd0);
        chk("resp_inst", cpu_inst, exp_inst(addr));
        tick();
    endtask

    task automatic hit_chk(input logic [31:0] addr);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        #1;
        chk("hit_stall", 32'(cpu_stall), 32'd0);
        chk("hit_mem_en", 32'(mem_en), 32'd0);
        chk("hit_inst", cpu_inst, exp_inst(addr));
        tick();
    endtask

    initial begin
        resetn    = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = 32'h0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_inst", cpu_inst, 32'h0);
`ifdef ICACHE_STATS_EN
        chk("rst_hit_cnt", hit_cnt, 32'h0);
        chk("rst_miss_cnt", miss_cnt, 32'h0);
`endif
        resetn = 1'b1;
        tick();

        // Cold miss on line 0, then sequential hits through the line
        miss_seq(32'h0000_0000, 0);
        for (int i = 1; i < 8; i++) begin
            hit_chk(32'(i * 4));
        end
        cpu_req = 1'b0;
        #1;
        chk("idle_stall", 32'(cpu_stall), 32'd0);
        chk("idle_inst", cpu_inst, 32'h0);
`ifdef ICACHE_STATS_EN
        tick();
        chk("stats_hit_cnt", hit_cnt, 32'd7);
        chk("stats_miss_cnt", miss_cnt, 32'd1);
`endif
        tick();

        // Conflict on index 0: new tag evicts, then the old line misses again
        miss_seq(32'h0000_0200, 0);
        hit_chk(32'h0000_0204);
        miss_seq(32'h0000_0000, 0);
        hit_chk(32'h0000_0018);

        // Memory back-pressure: ten cycles without mem_ready
        miss_seq(32'h0000_0044, 10);
        hit_chk(32'h0000_0040);

        // Reset while waiting for memory aborts the refill
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0088;
        tick();
        tick();
        tick();
        #1;
        chk("pre_rst_mem_en", 32'(mem_en), 32'd1);
        resetn = 1'b0;
        #1;
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        cpu_req = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        miss_seq(32'h0000_0088, 0);
        // Previously installed lines were invalidated by the reset
        miss_seq(32'h0000_0000, 0);
        hit_chk(32'h0000_0084);

        cpu_req = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
